// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: funct3 access
// encodings, the FSM state type and a funct3 legality helper.
package dmem_responder_pkg;

  // funct3 encodings for loads and stores (size in [1:0], unsigned in [2])
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Responder FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // True for the five access encodings the responder understands
  function automatic logic f3_legal(input logic [2:0] f3);
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data array: store write enables and lane
// replication, load lane extraction with sign/zero extension, and the
// alignment / encoding error flags that depend only on funct3 and addr[1:0].
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wword,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        illegal_f3
);

  logic [31:0] rshift;
  logic [15:0] rhalf;

  // Lane enables, store data replication and load extraction
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    byte_en    = 4'b0000;
    wword      = '0;
    load_data  = '0;
    misaligned = 1'b0;
    illegal_f3 = !f3_legal(funct3);
    rshift     = rword >> {byte_off, 3'b000};
    rhalf      = byte_off[1] ? rword[31:16] : rword[15:0];

    // Store side: the access size lives in funct3[1:0]
    unique case (funct3[1:0])
      2'b00: begin
        byte_en = 4'b0001 << byte_off;
        wword   = {4{wdata[7:0]}};
      end
      2'b01: begin
        byte_en    = byte_off[1] ? 4'b1100 : 4'b0011;
        wword      = {2{wdata[15:0]}};
        misaligned = byte_off[0];
      end
      default: begin
        byte_en    = 4'b1111;
        wword      = wdata;
        misaligned = (byte_off != 2'b00);
      end
    endcase

    // Load side: extend the selected lane(s) according to funct3
    unique case (funct3)
      F3_B:    load_data = {{24{rshift[7]}}, rshift[7:0]};
      F3_BU:   load_data = {24'd0, rshift[7:0]};
      F3_H:    load_data = {{16{rhalf[15]}}, rhalf};
      F3_HU:   load_data = {16'd0, rhalf};
      F3_W:    load_data = rword;
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder: accepts one load/store at a time in
// IDLE, holds it for WAIT_CYCLES cycles, performs the array access on the
// edge entering RESP and presents a one-cycle response pulse.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        dmem_read,
  input  logic        dmem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  output logic [31:0] rdata,
  output logic        rsp_err
);

  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q;
  logic                rd_q, wr_q;
  logic [2:0]          f3_q;
  logic [31:0]         addr_q, wdata_q;
  logic [31:0]         rdata_q;
  logic                err_q;

  logic                accept, enter_resp;
  logic                cur_rd, cur_wr;
  logic [2:0]          cur_f3;
  logic [31:0]         cur_addr, cur_wdata;
  logic [IDX_W-1:0]    word_idx;
  logic                in_range, acc_err, do_write;
  logic [31:0]         rword, wword, load_data, rdata_d;
  logic [3:0]          byte_en;
  logic                misaligned, illegal_f3;

  logic [31:0]         mem [DEPTH_WORDS];

  // A request carrying neither load nor store is never taken
  assign accept = req_valid && (state_q == ST_IDLE) && (dmem_read || dmem_write);

  // With zero wait states the access happens on the accept edge itself, so
  // the live inputs are used in IDLE and the latched copy otherwise.
  assign cur_rd    = (state_q == ST_IDLE) ? dmem_read  : rd_q;
  assign cur_wr    = (state_q == ST_IDLE) ? dmem_write : wr_q;
  assign cur_f3    = (state_q == ST_IDLE) ? funct3     : f3_q;
  assign cur_addr  = (state_q == ST_IDLE) ? addr       : addr_q;
  assign cur_wdata = (state_q == ST_IDLE) ? wdata      : wdata_q;

  assign word_idx  = cur_addr[IDX_W+1:2];
  assign in_range  = ((cur_addr[31:2] >> IDX_W) == '0);
  assign rword     = mem[word_idx];

  dmem_lane_align u_lane_align (
    .funct3     (cur_f3),
    .byte_off   (cur_addr[1:0]),
    .wdata      (cur_wdata),
    .rword      (rword),
    .byte_en    (byte_en),
    .wword      (wword),
    .load_data  (load_data),
    .misaligned (misaligned),
    .illegal_f3 (illegal_f3)
  );

  assign acc_err  = (cur_rd && cur_wr) || illegal_f3 || misaligned || !in_range;
  assign do_write = enter_resp && cur_wr && !cur_rd && !acc_err;
  assign rdata_d  = (cur_rd && !cur_wr && !acc_err) ? load_data : '0;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments keep every register updating from
    // pre-edge values, so the order of statements cannot create races.
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic, handshake and the RESP-entry strobe
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    enter_resp = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d    = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Wait-state counter: loaded on accept, counts down without wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     cnt_q <= 4'd0;
    else if (accept)                             cnt_q <= CNT_INIT;
    else if (state_q == ST_WAIT && cnt_q != '0)  cnt_q <= cnt_q - 4'd1;
  end

  // Request capture on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      rd_q    <= dmem_read;
      wr_q    <= dmem_write;
      f3_q    <= funct3;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  // Response data/error: loaded on RESP entry, cleared every other cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (enter_resp) begin
      rdata_q <= rdata_d;
      err_q   <= acc_err;
    end else begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end
  end

  // Data array byte-lane writes
  always_ff @(posedge clk) begin
    // NOTE: the array deliberately has no reset; contents survive rst and
    // the storage can map onto plain RAM.
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rdata     = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: a WAIT_CYCLES=2 instance driven with directed and
// random requests against a byte-level memory model, plus a WAIT_CYCLES=0
// instance driven back-to-back.
module tb_dmem_responder;

  localparam int DEPTH  = 64;
  localparam int WAITS  = 2;
  localparam int DEPTH0 = 256;
  localparam int BASE0  = 100000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, dmem_read, dmem_write, rsp_valid, rsp_err;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata;

  logic        b_req_valid, b_req_ready, b_dmem_read, b_dmem_write, b_rsp_valid, b_rsp_err;
  logic [2:0]  b_funct3;
  logic [31:0] b_addr, b_wdata, b_rdata;

  int checks = 0;
  int errors = 0;

  // Expected memory contents, keyed by (instance base + word index)
  logic [31:0] ref_mem [int];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
  } req_t;

  req_t        seq0 [$];
  logic        e_err;
  logic [31:0] e_rdata;
  logic        r_rd, r_wr;
  logic [2:0]  r_f3;
  logic [31:0] r_a, r_wd;
  int          r_sel;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITS)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rsp_valid(rsp_valid), .rdata(rdata),
    .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH0), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .dmem_read(b_dmem_read), .dmem_write(b_dmem_write), .funct3(b_funct3),
    .addr(b_addr), .wdata(b_wdata), .rsp_valid(b_rsp_valid), .rdata(b_rdata),
    .rsp_err(b_rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: access size from funct3, error rules, byte writes,
  // sign/zero-extended loads, all in plain arithmetic on whole words.
  function automatic void model(input int base, input int depth, input logic rd,
                                input logic wr, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic err,
                                output logic [31:0] rdat);
    int          size;
    int          widx;
    int          off;
    logic [31:0] w;
    case (f3[1:0])
      2'b00:   size = 1;
      2'b01:   size = 2;
      default: size = 4;
    endcase
    err = (rd && wr) || (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
          ((a % size) != 0) || ((a / 4) >= depth);
    rdat = '0;
    if (!err) begin
      widx = int'(a / 4);
      off  = int'(a % 4);
      w    = ref_mem.exists(base + widx) ? ref_mem[base + widx] : 'x;
      if (wr) begin
        for (int k = 0; k < size; k++) w[8*(off+k) +: 8] = wd[8*k +: 8];
        ref_mem[base + widx] = w;
      end else begin
        w = w >> (8 * off);
        case (size)
          1:       rdat = f3[2] ? {24'd0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
          2:       rdat = f3[2] ? {16'd0, w[15:0]} : {{16{w[15]}}, w[15:0]};
          default: rdat = w;
        endcase
      end
    end
  endfunction

  // One complete request on the WAIT_CYCLES=2 instance
  task automatic txn(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd);
    logic        x_err;
    logic [31:0] x_rdata;
    int          lat;
    model(0, DEPTH, rd, wr, f3, a, wd, x_err, x_rdata);
    @(negedge clk);
    check({tag, ".ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    dmem_read  = rd;
    dmem_write = wr;
    funct3     = f3;
    addr       = a;
    wdata      = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid  = 1'b0;
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    check({tag, ".busy"}, {28'd0, req_ready, rsp_valid, rsp_err, |rdata}, 32'd0);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    check({tag, ".lat"}, rsp_valid ? lat : 999, WAITS);
    check({tag, ".err"}, 32'(rsp_err), 32'(x_err));
    check({tag, ".rdata"}, rdata, x_rdata);
    @(negedge clk);
    check({tag, ".after"}, {28'd0, rsp_valid, rsp_err, |rdata, req_ready}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; dmem_read = 1'b0; dmem_write = 1'b0;
    funct3 = '0; addr = '0; wdata = '0;
    b_req_valid = 1'b0; b_dmem_read = 1'b0; b_dmem_write = 1'b0;
    b_funct3 = '0; b_addr = '0; b_wdata = '0;

    // Reset state of both instances
    @(negedge clk);
    check("rst.ready", 32'(req_ready), 32'd1);
    check("rst.rsp", {29'd0, rsp_valid, rsp_err, |rdata}, 32'd0);
    check("rst.ready0", 32'(b_req_ready), 32'd1);
    check("rst.rsp0", {29'd0, b_rsp_valid, b_rsp_err, |b_rdata}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Give every word a known random value
    for (int w = 0; w < DEPTH; w++) txn($sformatf("init%0d", w), 1'b0, 1'b1, 3'b010, 32'(w * 4), $urandom);

    // Aligned word store and load
    txn("sw10", 1'b0, 1'b1, 3'b010, 32'h10, 32'h1234_5678);
    txn("lw10", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    check("lw10.const", rdata === 32'h0 ? 32'd1 : 32'd0, 32'd1);

    // Byte store, signed/unsigned byte loads, neighbouring lanes
    txn("sb21", 1'b0, 1'b1, 3'b000, 32'h21, 32'h0000_0080);
    txn("lb21", 1'b1, 1'b0, 3'b000, 32'h21, 32'h0);
    txn("lbu21", 1'b1, 1'b0, 3'b100, 32'h21, 32'h0);
    txn("lw20a", 1'b1, 1'b0, 3'b010, 32'h20, 32'h0);

    // Misaligned accesses leave memory untouched
    txn("lh13", 1'b1, 1'b0, 3'b001, 32'h13, 32'h0);
    txn("sw22", 1'b0, 1'b1, 3'b010, 32'h22, 32'hFFFF_FFFF);
    txn("lw20b", 1'b1, 1'b0, 3'b010, 32'h20, 32'h0);

    // Range boundary, both read+write, half-word lanes
    txn("lwtop", 1'b1, 1'b0, 3'b010, 32'(DEPTH * 4), 32'h0);
    txn("lwlast", 1'b1, 1'b0, 3'b010, 32'(DEPTH * 4 - 4), 32'h0);
    txn("rdwr", 1'b1, 1'b1, 3'b010, 32'h24, 32'hCAFE_F00D);
    txn("lw24", 1'b1, 1'b0, 3'b010, 32'h24, 32'h0);
    txn("sh26", 1'b0, 1'b1, 3'b001, 32'h26, 32'h0000_9ABC);
    txn("lh26", 1'b1, 1'b0, 3'b001, 32'h26, 32'h0);
    txn("lhu26", 1'b1, 1'b0, 3'b101, 32'h26, 32'h0);
    txn("f3bad", 1'b1, 1'b0, 3'b011, 32'h28, 32'h0);

    // Request with neither read nor write is refused
    @(negedge clk);
    req_valid = 1'b1; funct3 = 3'b010; addr = 32'h30;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("refuse%0d", i), {30'd0, req_ready, rsp_valid}, 32'd2);
    end
    req_valid = 1'b0;

    // Reset during the wait states drops the store
    @(negedge clk);
    req_valid = 1'b1; dmem_write = 1'b1; funct3 = 3'b010; addr = 32'h40; wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; dmem_write = 1'b0;
    check("rstw.busy", 32'(req_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("rstw.async", {30'd0, req_ready, rsp_valid}, 32'd2);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("rstw.idle%0d", i), {30'd0, req_ready, rsp_valid}, 32'd2);
    end
    txn("rstw.lw40", 1'b1, 1'b0, 3'b010, 32'h40, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      r_sel = $urandom_range(0, 9);
      r_rd  = (r_sel <= 4);
      r_wr  = (r_sel == 0) || (r_sel >= 5);
      r_f3  = 3'($urandom_range(0, 7));
      r_a   = 32'($urandom_range(0, DEPTH * 4 + 15));
      if ($urandom_range(0, 1) == 0) r_a[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) r_a[31] = 1'b1;
      r_wd  = $urandom;
      txn($sformatf("rnd%0d", i), r_rd, r_wr, r_f3, r_a, r_wd);
    end

    // Full read-back against the model
    for (int w = 0; w < DEPTH; w++) txn($sformatf("rb%0d", w), 1'b1, 1'b0, 3'b010, 32'(w * 4), 32'h0);

    // Zero-wait-state instance with req_valid held high throughout
    seq0.push_back('{1'b0, 1'b1, 3'b010, 32'h0, 32'h8765_4321});
    seq0.push_back('{1'b0, 1'b1, 3'b010, 32'h4, 32'h0BAD_CAFE});
    seq0.push_back('{1'b0, 1'b1, 3'b000, 32'h5, 32'h0000_00F1});
    seq0.push_back('{1'b1, 1'b0, 3'b010, 32'h0, 32'h0});
    seq0.push_back('{1'b1, 1'b0, 3'b010, 32'h4, 32'h0});
    seq0.push_back('{1'b1, 1'b0, 3'b100, 32'h5, 32'h0});
    seq0.push_back('{1'b1, 1'b0, 3'b001, 32'h2, 32'h0});
    seq0.push_back('{1'b0, 1'b1, 3'b010, 32'h9, 32'h1111_1111});
    seq0.push_back('{1'b1, 1'b0, 3'b000, 32'h5, 32'h0});
    @(negedge clk);
    for (int j = 0; j < seq0.size(); j++) begin
      model(BASE0, DEPTH0, seq0[j].rd, seq0[j].wr, seq0[j].f3, seq0[j].a, seq0[j].wd, e_err, e_rdata);
      b_req_valid  = 1'b1;
      b_dmem_read  = seq0[j].rd;
      b_dmem_write = seq0[j].wr;
      b_funct3     = seq0[j].f3;
      b_addr       = seq0[j].a;
      b_wdata      = seq0[j].wd;
      check($sformatf("b2b%0d.ready", j), 32'(b_req_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("b2b%0d.rsp", j), {30'd0, b_rsp_valid, b_req_ready}, 32'd2);
      check($sformatf("b2b%0d.err", j), 32'(b_rsp_err), 32'(e_err));
      check($sformatf("b2b%0d.rdata", j), b_rdata, e_rdata);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("b2b%0d.gap", j), {29'd0, b_rsp_valid, b_rsp_err, |b_rdata}, 32'd0);
    end
    b_req_valid = 1'b0;
    b_dmem_read = 1'b0;
    b_dmem_write = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
